// File: rtl/shift_arbiter_if.sv
// Request/response bundle between the two requesters and the shift arbiter.
// The slave modport is the arbiter side; the master modport is the requester side.
interface shift_arbiter_if #(
    parameter int NPORT_ID_W = 4
);
    logic                  req0_valid;
    logic                  req0_ready;
    logic [31:0]           req0_a;
    logic [4:0]            req0_b;
    logic [1:0]            req0_op;
    logic [NPORT_ID_W-1:0] req0_tag;
    logic                  req1_valid;
    logic                  req1_ready;
    logic [31:0]           req1_a;
    logic [4:0]            req1_b;
    logic [1:0]            req1_op;
    logic [NPORT_ID_W-1:0] req1_tag;
    logic                  rsp0_valid;
    logic                  rsp0_ready;
    logic                  rsp1_valid;
    logic                  rsp1_ready;
    logic [31:0]           rsp_result;
    logic [NPORT_ID_W-1:0] rsp_tag;
    logic [15:0]           busy_cnt;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op, req0_tag,
        input  req1_valid, req1_a, req1_b, req1_op, req1_tag,
        input  rsp0_ready, rsp1_ready,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
        output rsp_result, rsp_tag, busy_cnt
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op, req0_tag,
        output req1_valid, req1_a, req1_b, req1_op, req1_tag,
        output rsp0_ready, rsp1_ready,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
        input  rsp_result, rsp_tag, busy_cnt
    );
endinterface

// File: rtl/shift_arbiter.sv
// Two-port round-robin front end for one shared combinational shifter.
// A single registered result slot drains and refills in the same cycle.
module shifter (
    input  logic [31:0] a_i,
    input  logic [4:0]  b_i,
    input  logic [1:0]  op_i,
    output logic [31:0] y_o
);
    always_comb begin
        case (op_i)
            2'b10:   y_o = a_i >> b_i;
            2'b11:   y_o = $signed(a_i) >>> b_i;
            default: y_o = a_i << b_i;
        endcase
    end
endmodule

module shift_arbiter #(
    parameter int NPORT_ID_W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    shift_arbiter_if.slave bus
);
    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_e;

    typedef struct packed {
        logic [31:0]           a;
        logic [4:0]            b;
        logic [1:0]            op;
        logic [NPORT_ID_W-1:0] tag;
    } req_t;

    state_e                state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  last_grant_q, last_grant_d;
    logic [31:0]           result_q, result_d;
    logic [NPORT_ID_W-1:0] tag_q, tag_d;
    logic [15:0]           busy_q, busy_d;

    req_t        req0, req1, sel;
    logic        cand, cand_valid, owner_rdy, slot_free, accept, any_valid;
    logic [31:0] shift_y;

    assign req0 = '{a: bus.req0_a, b: bus.req0_b, op: bus.req0_op, tag: bus.req0_tag};
    assign req1 = '{a: bus.req1_a, b: bus.req1_b, op: bus.req1_op, tag: bus.req1_tag};
    assign any_valid = bus.req0_valid | bus.req1_valid;

    // Ties go to the port that did not win last; a lone requester always wins.
    always_comb begin
        cand = ~last_grant_q;
        if (bus.req0_valid && !bus.req1_valid)
            cand = 1'b0;
        else if (bus.req1_valid && !bus.req0_valid)
            cand = 1'b1;
    end

    assign cand_valid = cand ? bus.req1_valid : bus.req0_valid;
    assign owner_rdy  = owner_q ? bus.rsp1_ready : bus.rsp0_ready;
    // rst_n gating keeps both readies low for the whole reset window.
    assign slot_free  = rst_n && ((state_q == IDLE) || owner_rdy);
    assign accept     = slot_free && cand_valid;
    assign sel        = cand ? req1 : req0;

    shifter u_shifter (
        .a_i  (sel.a),
        .b_i  (sel.b),
        .op_i (sel.op),
        .y_o  (shift_y)
    );

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        result_d     = result_q;
        tag_d        = tag_q;
        busy_d       = busy_q;
        if (accept) begin
            state_d      = HOLD;
            owner_d      = cand;
            last_grant_d = cand;
            result_d     = shift_y;
            tag_d        = sel.tag;
        end else if (state_q == HOLD && owner_rdy) begin
            state_d = IDLE;
        end
        if (any_valid && !accept && busy_q != 16'hFFFF)
            busy_d = busy_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            result_q     <= '0;
            tag_q        <= '0;
            busy_q       <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            result_q     <= result_d;
            tag_q        <= tag_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.req0_ready = slot_free && !cand;
    assign bus.req1_ready = slot_free && cand;
    assign bus.rsp0_valid = (state_q == HOLD) && !owner_q;
    assign bus.rsp1_valid = (state_q == HOLD) && owner_q;
    assign bus.rsp_result = result_q;
    assign bus.rsp_tag    = tag_q;
    assign bus.busy_cnt   = busy_q;
endmodule
